adc_rx_align_ctrl: RTL
======================

// Module: adc_rx_align_ctrl
// PURPOSE
//  Per-lane IDELAY eye scan plus bitslip word alignment for the 16-lane 8:1 ADC deserializer.
//  Sits in the rxclkdiv domain beside the deserializer and owns its manual_* delay/bitslip controls.
//  Lanes are processed sequentially; the block reports per-lane centre taps, a fail mask and the
//  global data-good flag.
// PARAMETERS
//  NCHAN      16      lanes handled (chan_sel is 4 bits, NCHAN<=16)
//  TAP_MAX    31      highest IDELAY tap; taps are 5 bits
//  SETTLE     16      cycles to wait after any inc/dec/bitslip/idly_rst before sampling
//  SAMPLE     64      sample window per tap, in cycles
//  PATTERN    8'hF0   training word the ADC emits while training
//  MIN_EYE    4       minimum good-run length (taps) for a lane to pass
// PORTS
//  clk             in   1         rxclkdiv clock
//  rst             in   1         async active-high reset
//  training_start  in   1         rising edge starts a full training pass
//  data_in         in   8*NCHAN   deserialized words; lane k = data_in[8k+7:8k]
//  manual_enable   out  1         high while the block drives the delay controls
//  manual_chan_sel out  4         lane under training
//  manual_inc      out  1         1-cycle tap increment pulse
//  manual_dec      out  1         1-cycle tap decrement pulse
//  manual_bitslip  out  1         1-cycle bitslip pulse
//  manual_idly_rst out  1         1-cycle IDELAY reset pulse (tap -> 0)
//  training_done   out  1         high once a pass completes; cleared by the next start
//  rxdataisgood    out  1         training_done and fail_mask==0
//  fail_mask       out  NCHAN     bit k = lane k failed its eye or its bitslip
//  tap             out  5*NCHAN   final centre tap per lane
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE. An assertion mid-pass aborts at once; no pulses follow.
//  Start: one-cycle rising-edge detect on training_start. The detect is accepted in IDLE or DONE
//   and ignored in every other state. Acceptance clears training_done, fail_mask and tap,
//   sets lane=0 and manual_enable=1.
//  manual_enable stays 1 from acceptance until DONE. chan_sel is stable for the whole of a lane.
//  At most one of inc/dec/bitslip/idly_rst is high in any cycle.
//  FSM:
//   IDLE -> LRST: pulse idly_rst; cur_tap=0; run_len=0; best_len=0; best_start=0.
//   LRST/STEP/SLIP -> WAIT: count SETTLE cycles, then go to SAMP.
//   SAMP: latch the first word; over SAMPLE cycles, tap is good iff every word equals the first.
//    good: run_len++; if run_len is 0 before the increment, run_start=cur_tap.
//    bad: close the run; run_len=0.
//    Closing a run: if run_len>best_len (strict), best_len=run_len and best_start=run_start.
//     Ties keep the earlier run.
//   After SAMP: if cur_tap<TAP_MAX -> STEP (pulse inc, cur_tap++, WAIT).
//    At TAP_MAX, close any open run (an eye that reaches the top tap counts), then go to CENT.
//   CENT: centre = best_start + (best_len>>1), 5-bit.
//    If best_len<MIN_EYE, set fail_mask[lane] and go to NEXT (no centring, no slip).
//    Otherwise issue (TAP_MAX-centre) dec pulses, one every 2 cycles, with a final WAIT,
//    then store centre into tap[lane].
//   SCHK: compare one word to PATTERN after settle.
//    Match -> NEXT.
//    Mismatch -> pulse bitslip, WAIT, SCHK again, for up to 8 slips.
//    9th mismatch -> set fail_mask[lane], NEXT.
//   NEXT: if lane==NCHAN-1 -> DONE, else lane++ and go to LRST.
//   DONE: training_done=1, manual_enable=0, chan_sel=0, rxdataisgood = (fail_mask==0).
//  Latency: a lane with a clean eye and zero slips takes about
//   (TAP_MAX+1)*(SETTLE+SAMPLE+1) + 2*(TAP_MAX-centre) + 2*SETTLE cycles.
// TESTING
//  Bench models the lanes: each lane has an eye window [lo,hi] and a slip offset.
//   Inside the window it outputs ROTL(PATTERN, offset); outside the window it outputs a random word per cycle.
//  T1: all lanes eye [8,20], offset 0 -> tap[k]=14, 17 dec pulses per lane, 0 bitslips,
//      fail_mask=0, rxdataisgood=1.
//  T2: lane 3 eyes [2,5] and [10,14] (tie-free), offset 3 -> tap[3]=12; slips issued so the lane
//      reaches PATTERN (e.g. 5 slips if each slip rotates by 1); other lanes as T1.
//  T3: lane 7 eye [26,31] (run reaching TAP_MAX) -> tap[7]=29, 2 dec pulses.
//      Lane 9 eye [0,2] (len 3 < MIN_EYE) -> fail_mask=16'h0200, rxdataisgood=0.
//  T4: lane 5 never matches PATTERN -> exactly 8 bitslip pulses, fail_mask[5]=1, pass still completes.
//  T5: rst asserted mid-SAMP on lane 6 -> outputs 0 same cycle.
//      A new start after release runs a full pass from lane 0.
//  T6: training_start toggled mid-pass -> ignored.
//      Start asserted again in DONE -> training_done drops for one pass and results are recomputed.

Source files
------------

// File: rtl/adc_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_rx_align_ctrl
//  Description : Per-lane IDELAY eye scan, eye centring and bitslip word
//                alignment for a multi-lane 8:1 ADC deserializer.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_rx_align_ctrl #(
    parameter int          NCHAN   = 16,
    parameter int          TAP_MAX = 31,
    parameter int          SETTLE  = 16,
    parameter int          SAMPLE  = 64,
    parameter logic [7:0]  PATTERN = 8'hF0,
    parameter int          MIN_EYE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 training_start,
    input  logic [8*NCHAN-1:0]   data_in,
    output logic                 manual_enable,
    output logic [3:0]           manual_chan_sel,
    output logic                 manual_inc,
    output logic                 manual_dec,
    output logic                 manual_bitslip,
    output logic                 manual_idly_rst,
    output logic                 training_done,
    output logic                 rxdataisgood,
    output logic [NCHAN-1:0]     fail_mask,
    output logic [5*NCHAN-1:0]   tap
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE - 1);
    localparam logic [4:0]  TAP_TOP     = 5'(TAP_MAX);
    localparam logic [3:0]  LAST_LANE   = 4'(NCHAN - 1);
    localparam logic [5:0]  MIN_LEN     = 6'(MIN_EYE);
    localparam logic [3:0]  MAX_SLIPS   = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE, S_LRST, S_WAIT, S_SAMP, S_STEP,
        S_CENT, S_DECP, S_SCHK, S_NEXT, S_DONE
    } state_t;

    state_t               state_q, state_d, ret_q, ret_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           lane_q, lane_d;
    logic [4:0]           cur_tap_q, cur_tap_d;
    logic [5:0]           run_len_q, run_len_d, best_len_q, best_len_d;
    logic [4:0]           run_start_q, run_start_d, best_start_q, best_start_d;
    logic [4:0]           centre_q, centre_d, dec_left_q, dec_left_d;
    logic                 phase_q, phase_d;
    logic [3:0]           slips_q, slips_d;
    logic [7:0]           first_q, first_d;
    logic                 good_q, good_d;
    logic                 start_prev_q, start_prev_d;
    logic                 enable_q, enable_d;
    logic                 inc_q, inc_d, dec_q, dec_d;
    logic                 bitslip_q, bitslip_d, idly_rst_q, idly_rst_d;
    logic                 done_q, done_d, dgood_q, dgood_d;
    logic [NCHAN-1:0]     fail_q, fail_d;
    logic [5*NCHAN-1:0]   tap_q, tap_d;

    logic [7:0]           word;
    logic                 start_edge;
    logic                 tap_good;
    logic [5:0]           nlen, blen;
    logic [4:0]           nstart, bstart, ctr;

    assign word       = data_in[{lane_q, 3'b000} +: 8];
    assign start_edge = training_start & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        cur_tap_d    = cur_tap_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        centre_d     = centre_q;
        dec_left_d   = dec_left_q;
        phase_d      = phase_q;
        slips_d      = slips_q;
        first_d      = first_q;
        good_d       = good_q;
        start_prev_d = training_start;
        enable_d     = enable_q;
        inc_d        = 1'b0;
        dec_d        = 1'b0;
        bitslip_d    = 1'b0;
        idly_rst_d   = 1'b0;
        done_d       = done_q;
        dgood_d      = dgood_q;
        fail_d       = fail_q;
        tap_d        = tap_q;
        tap_good     = 1'b0;
        nlen         = run_len_q;
        nstart       = run_start_q;
        blen         = best_len_q;
        bstart       = best_start_q;
        ctr          = best_start_q + best_len_q[5:1];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d  = S_LRST;
                    done_d   = 1'b0;
                    dgood_d  = 1'b0;
                    fail_d   = '0;
                    tap_d    = '0;
                    lane_d   = 4'd0;
                    enable_d = 1'b1;
                end
            end
            S_LRST: begin
                idly_rst_d   = 1'b1;
                cur_tap_d    = 5'd0;
                run_len_d    = 6'd0;
                run_start_d  = 5'd0;
                best_len_d   = 6'd0;
                best_start_d = 5'd0;
                slips_d      = 4'd0;
                cnt_d        = 16'd0;
                ret_d        = S_SAMP;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    good_d  = 1'b1;
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SAMP: begin
                tap_good = good_q & ((cnt_q == 16'd0) || (word == first_q));
                good_d   = tap_good;
                if (cnt_q == 16'd0) first_d = word;
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d = 16'd0;
                    if (tap_good) begin
                        if (nlen == 6'd0) nstart = cur_tap_q;
                        nlen = nlen + 6'd1;
                    end else begin
                        if (nlen > blen) begin
                            blen   = nlen;
                            bstart = nstart;
                        end
                        nlen = 6'd0;
                    end
                    // A run still open at the top tap is a valid eye edge.
                    if (cur_tap_q == TAP_TOP) begin
                        if (nlen > blen) begin
                            blen   = nlen;
                            bstart = nstart;
                        end
                        nlen    = 6'd0;
                        state_d = S_CENT;
                    end else begin
                        state_d = S_STEP;
                    end
                    run_len_d    = nlen;
                    run_start_d  = nstart;
                    best_len_d   = blen;
                    best_start_d = bstart;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STEP: begin
                inc_d     = 1'b1;
                cur_tap_d = cur_tap_q + 5'd1;
                cnt_d     = 16'd0;
                ret_d     = S_SAMP;
                state_d   = S_WAIT;
            end
            S_CENT: begin
                if (best_len_q < MIN_LEN) begin
                    fail_d[lane_q] = 1'b1;
                    state_d        = S_NEXT;
                end else begin
                    centre_d   = ctr;
                    dec_left_d = TAP_TOP - ctr;
                    phase_d    = 1'b0;
                    state_d    = S_DECP;
                end
            end
            S_DECP: begin
                // Walk down from the top tap, one decrement every other cycle.
                if (dec_left_q == 5'd0) begin
                    tap_d[5*lane_q +: 5] = centre_q;
                    cnt_d   = 16'd0;
                    ret_d   = S_SCHK;
                    state_d = S_WAIT;
                end else if (!phase_q) begin
                    dec_d      = 1'b1;
                    dec_left_d = dec_left_q - 5'd1;
                    phase_d    = 1'b1;
                end else begin
                    phase_d = 1'b0;
                end
            end
            S_SCHK: begin
                if (word == PATTERN) begin
                    state_d = S_NEXT;
                end else if (slips_q == MAX_SLIPS) begin
                    fail_d[lane_q] = 1'b1;
                    state_d        = S_NEXT;
                end else begin
                    bitslip_d = 1'b1;
                    slips_d   = slips_q + 4'd1;
                    cnt_d     = 16'd0;
                    ret_d     = S_SCHK;
                    state_d   = S_WAIT;
                end
            end
            S_NEXT: begin
                if (lane_q == LAST_LANE) begin
                    lane_d   = 4'd0;
                    enable_d = 1'b0;
                    done_d   = 1'b1;
                    dgood_d  = (fail_q == '0);
                    state_d  = S_DONE;
                end else begin
                    lane_d  = lane_q + 4'd1;
                    state_d = S_LRST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            cnt_q        <= '0;
            lane_q       <= '0;
            cur_tap_q    <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            centre_q     <= '0;
            dec_left_q   <= '0;
            phase_q      <= 1'b0;
            slips_q      <= '0;
            first_q      <= '0;
            good_q       <= 1'b0;
            start_prev_q <= 1'b0;
            enable_q     <= 1'b0;
            inc_q        <= 1'b0;
            dec_q        <= 1'b0;
            bitslip_q    <= 1'b0;
            idly_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            dgood_q      <= 1'b0;
            fail_q       <= '0;
            tap_q        <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            cur_tap_q    <= cur_tap_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            centre_q     <= centre_d;
            dec_left_q   <= dec_left_d;
            phase_q      <= phase_d;
            slips_q      <= slips_d;
            first_q      <= first_d;
            good_q       <= good_d;
            start_prev_q <= start_prev_d;
            enable_q     <= enable_d;
            inc_q        <= inc_d;
            dec_q        <= dec_d;
            bitslip_q    <= bitslip_d;
            idly_rst_q   <= idly_rst_d;
            done_q       <= done_d;
            dgood_q      <= dgood_d;
            fail_q       <= fail_d;
            tap_q        <= tap_d;
        end
    end

    assign manual_enable   = enable_q;
    assign manual_chan_sel = lane_q;
    assign manual_inc      = inc_q;
    assign manual_dec      = dec_q;
    assign manual_bitslip  = bitslip_q;
    assign manual_idly_rst = idly_rst_q;
    assign training_done   = done_q;
    assign rxdataisgood    = dgood_q;
    assign fail_mask       = fail_q;
    assign tap             = tap_q;

endmodule
`default_nettype wire
